vga_pixel_fetch: RTL and testbench

//  Pixel source feeding the VGA controller's iRed/iGreen/iBlue inputs. Tracks
//  the active-area pixel position from the controller's request strobe, reads a

---
 rtl/vga_pixel_fetch_pkg.sv | 16 +
 rtl/vga_palette.sv | 40 ++++
 rtl/vga_pixel_fetch.sv | 139 +++++++++++++
 tb/tb_vga_pixel_fetch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pixel_fetch_pkg.sv
// vga_pixel_fetch_pkg: display geometry and colour defaults shared by the
// VGA pixel source, the VGA controller and the system top.
package vga_pixel_fetch_pkg;

    localparam int RGB_SIZE_D = 8;
    localparam int H_ACTIVE_D = 640;
    localparam int V_ACTIVE_D = 480;
    localparam int IDX_W_D    = 4;
    localparam int ADDR_W_D   = 19;

    // Width of one palette entry {R,G,B}.
    function automatic int pal_w(input int rgb_size);
        return 3 * rgb_size;
    endfunction

endpackage

// File: rtl/vga_palette.sv
// vga_palette: 2**IDX_W entry colour palette, one write port, one
// registered read port. Ports: i_clk, i_rst_n, i_we/i_waddr/i_wdata (write),
// i_raddr (lookup index), o_rdata (entry, valid the cycle after i_raddr).
module vga_palette #(
    parameter int IDX_W = 4,
    parameter int ENT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [ENT_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [ENT_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [ENT_W-1:0] r_rdata;

    // Read samples the array before this edge's write lands, so a
    // same-cycle write to the looked-up entry returns the old colour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: tracks the active pixel position from iRequest, reads the
// palette-indexed framebuffer (oMem_Addr -> iMem_Data one cycle later) and
// maps each index through the palette onto oRed/oGreen/oBlue two cycles after
// the request. iVGA_V_SYNC falling edge restarts the frame and samples iZoom
// (2x2 replication from a half-size framebuffer). iPal_* write the palette.
module vga_pixel_fetch
    import vga_pixel_fetch_pkg::*;
#(
    parameter int RGB_SIZE = RGB_SIZE_D,
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int IDX_W    = IDX_W_D,
    parameter int ADDR_W   = ADDR_W_D
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iRequest,
    input  logic                  iVGA_V_SYNC,
    input  logic                  iZoom,
    output logic [ADDR_W-1:0]     oMem_Addr,
    input  logic [IDX_W-1:0]      iMem_Data,
    input  logic                  iPal_We,
    input  logic [IDX_W-1:0]      iPal_Addr,
    input  logic [3*RGB_SIZE-1:0] iPal_Data,
    output logic [RGB_SIZE-1:0]   oRed,
    output logic [RGB_SIZE-1:0]   oGreen,
    output logic [RGB_SIZE-1:0]   oBlue
);

    localparam int ENT_W = pal_w(RGB_SIZE);
    localparam int XW    = $clog2(H_ACTIVE);
    localparam int YW    = $clog2(V_ACTIVE);

    localparam logic [XW-1:0]     X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_FULL = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_HALF = ADDR_W'(H_ACTIVE / 2);

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_zoom;
    logic              r_vs_q;
    logic              r_v1;
    logic              r_v2;

    logic              w_vs_fall;
    logic [XW-1:0]     w_x;
    logic [YW-1:0]     w_y;
    logic [ADDR_W-1:0] w_rb;
    logic              w_zoom;
    logic [ADDR_W-1:0] w_col;
    logic [XW-1:0]     w_x_nxt;
    logic [YW-1:0]     w_y_nxt;
    logic [ADDR_W-1:0] w_rb_nxt;
    logic [ENT_W-1:0]  w_pal_q;

    assign w_vs_fall = r_vs_q & ~iVGA_V_SYNC;

    // A vsync edge overrides the position in the same cycle, so a
    // coincident request is served from (0,0).
    always_comb begin
        w_x    = r_x;
        w_y    = r_y;
        w_rb   = r_row_base;
        w_zoom = r_zoom;
        if (w_vs_fall) begin
            w_x    = '0;
            w_y    = '0;
            w_rb   = '0;
            w_zoom = iZoom;
        end
    end

    assign w_col     = w_zoom ? ADDR_W'(w_x >> 1) : ADDR_W'(w_x);
    assign oMem_Addr = w_rb + w_col;

    // In zoom mode each source row is shown twice, so the row base
    // only advances after odd display lines.
    always_comb begin
        w_x_nxt  = w_x;
        w_y_nxt  = w_y;
        w_rb_nxt = w_rb;
        if (iRequest) begin
            if (w_x == X_LAST) begin
                w_x_nxt = '0;
                if (w_y == Y_LAST) begin
                    w_y_nxt  = '0;
                    w_rb_nxt = '0;
                end else begin
                    w_y_nxt = w_y + YW'(1);
                    if (!w_zoom) begin
                        w_rb_nxt = w_rb + LINE_FULL;
                    end else if (w_y[0]) begin
                        w_rb_nxt = w_rb + LINE_HALF;
                    end
                end
            end else begin
                w_x_nxt = w_x + XW'(1);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_zoom     <= 1'b0;
            r_vs_q     <= 1'b1;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
        end else begin
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_row_base <= w_rb_nxt;
            r_zoom     <= w_zoom;
            r_vs_q     <= iVGA_V_SYNC;
            r_v1       <= iRequest;
            r_v2       <= r_v1;
        end
    end

    vga_palette #(
        .IDX_W (IDX_W),
        .ENT_W (ENT_W)
    ) u_palette (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_we    (iPal_We),
        .i_waddr (iPal_Addr),
        .i_wdata (iPal_Data),
        .i_raddr (iMem_Data),
        .o_rdata (w_pal_q)
    );

    assign {oRed, oGreen, oBlue} = r_v2 ? w_pal_q : '0;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: randomized and directed stimulus for vga_pixel_fetch,
// checked against a frame-position / palette reference model.
module tb_vga_pixel_fetch;

    localparam int H = 640;
    localparam int V = 480;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iRequest;
    logic        iVGA_V_SYNC;
    logic        iZoom;
    logic [18:0] oMem_Addr;
    logic [3:0]  iMem_Data;
    logic        iPal_We;
    logic [3:0]  iPal_Addr;
    logic [23:0] iPal_Data;
    logic [7:0]  oRed;
    logic [7:0]  oGreen;
    logic [7:0]  oBlue;

    always #5 iCLK = ~iCLK;

    vga_pixel_fetch dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iRequest    (iRequest),
        .iVGA_V_SYNC (iVGA_V_SYNC),
        .iZoom       (iZoom),
        .oMem_Addr   (oMem_Addr),
        .iMem_Data   (iMem_Data),
        .iPal_We     (iPal_We),
        .iPal_Addr   (iPal_Addr),
        .iPal_Data   (iPal_Data),
        .oRed        (oRed),
        .oGreen      (oGreen),
        .oBlue       (oBlue)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Framebuffer contents: a hash of the address, re-keyed via seed.
    logic [3:0] seed;

    function automatic logic [3:0] fdat(input logic [18:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ seed;
    endfunction

    always @(posedge iCLK) iMem_Data <= fdat(oMem_Addr);

    // Reference model: p = pixels requested since frame start.
    int          p;
    bit          zm;
    bit          vs_prev;
    logic [23:0] pal_m [16];
    bit          pend_v;
    logic [3:0]  pend_idx;
    logic [23:0] exp_rgb;
    logic [23:0] last_rgb;
    logic [18:0] last_addr;

    function automatic logic [18:0] model_addr();
        int x = p % H;
        int y = p / H;
        if (zm) return 19'((y / 2) * (H / 2) + x / 2);
        return 19'(y * H + x);
    endfunction

    task automatic model_reset();
        p       = 0;
        zm      = 0;
        vs_prev = 1;
        pend_v  = 0;
        exp_rgb = '0;
        for (int i = 0; i < 16; i++) pal_m[i] = '0;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input bit req, input bit vs, input bit zin,
                        input bit we, input logic [3:0] wa,
                        input logic [23:0] wd);
        iRequest    = req;
        iVGA_V_SYNC = vs;
        iZoom       = zin;
        iPal_We     = we;
        iPal_Addr   = wa;
        iPal_Data   = wd;
        if (vs_prev && !vs) begin
            p  = 0;
            zm = zin;
        end
        vs_prev = vs;
        @(negedge iCLK);
        last_rgb  = {oRed, oGreen, oBlue};
        last_addr = oMem_Addr;
        chk("rgb", last_rgb, exp_rgb);
        if (req) chk("addr", oMem_Addr, model_addr());
        exp_rgb = pend_v ? pal_m[pend_idx] : 24'h0;
        if (we) pal_m[wa] = wd;
        pend_v = req;
        if (req) begin
            pend_idx = fdat(model_addr());
            p = (p + 1) % (H * V);
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 4'h0, 24'h0);
    endtask

    task automatic reqs(input int n, input bit zin);
        for (int i = 0; i < n; i++) step(1, 1, zin, 0, 4'h0, 24'h0);
    endtask

    task automatic pal_fill();
        for (int i = 0; i < 16; i++)
            step(0, 1, 0, 1, 4'(i), 24'($urandom));
    endtask

    task automatic seed_for(input logic [3:0] idx);
        logic [18:0] a;
        a    = model_addr();
        seed = a[3:0] ^ a[7:4] ^ a[11:8] ^ idx;
    endtask

    initial begin
        iRST_N      = 1'b0;
        iRequest    = 1'b0;
        iVGA_V_SYNC = 1'b1;
        iZoom       = 1'b0;
        iPal_We     = 1'b0;
        iPal_Addr   = '0;
        iPal_Data   = '0;
        seed        = 4'h3;
        model_reset();
        #12;
        chk("reset_rgb", {oRed, oGreen, oBlue}, 24'h0);
        chk("reset_addr", oMem_Addr, 19'h0);
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;

        // Latency: palette[3]=FF0000, RAM[0]=3, request at cycle 10.
        step(0, 1, 0, 1, 4'h3, 24'hFF0000);
        idle(9);
        step(1, 1, 0, 0, 4'h0, 24'h0);
        idle(1);
        chk("lat_c11", last_rgb, 24'h0);
        idle(1);
        chk("lat_c12", last_rgb, 24'hFF0000);
        idle(1);
        chk("lat_c13", last_rgb, 24'h0);

        // Reset mid-stream with requests in flight.
        pal_fill();
        seed = 4'(($urandom));
        reqs(20, 0);
        iRequest = 1'b1;
        iRST_N   = 1'b0;
        #1;
        chk("rst_mid_rgb", {oRed, oGreen, oBlue}, 24'h0);
        model_reset();
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        step(1, 1, 0, 0, 4'h0, 24'h0);
        chk("rst_first_addr", last_addr, 19'h0);

        // Line wrap without zoom.
        pal_fill();
        step(0, 0, 0, 0, 4'h0, 24'h0);
        idle(2);
        reqs(H, 0);
        step(1, 1, 0, 0, 4'h0, 24'h0);
        chk("wrap_y1", last_addr, 19'd640);

        // Zoom: three lines.
        step(0, 0, 1, 0, 4'h0, 24'h0);
        idle(1);
        reqs(2 * H, 0);
        step(1, 1, 0, 0, 4'h0, 24'h0);
        chk("zoom_l2", last_addr, 19'd320);
        reqs(H - 1, 1);

        // Palette write/lookup hazard on entry 5.
        step(0, 1, 0, 1, 4'h5, 24'h00000F);
        seed_for(4'h5);
        step(1, 1, 0, 0, 4'h0, 24'h0);
        seed_for(4'h5);
        step(1, 1, 0, 1, 4'h5, 24'h00FF00);
        idle(1);
        chk("haz_old", last_rgb, 24'h00000F);
        idle(1);
        chk("haz_new", last_rgb, 24'h00FF00);

        // Vsync mid-frame at x=100, y=7; iZoom toggles without effect.
        seed = 4'(($urandom));
        step(0, 0, 0, 0, 4'h0, 24'h0);
        idle(1);
        reqs(7 * H + 90, 0);
        reqs(10, 1);
        step(1, 0, 0, 0, 4'h0, 24'h0);
        chk("vs_mid_addr", last_addr, 19'h0);
        reqs(H + 5, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit req, vs, zin, we;
            req = ($urandom % 10) < 7;
            vs  = ($urandom % 300) != 0;
            zin = $urandom % 2;
            we  = ($urandom % 10) == 0;
            if (($urandom % 50) == 0) seed = 4'(($urandom));
            step(req, vs, zin, we, 4'(($urandom)), 24'($urandom));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
